// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if
// Purpose : Bundles the ID-stage query, EX kill, completion port and the
//           scoreboard status outputs of hazard_scoreboard.
// Signals : id_valid, id_rs1/rs2/rd, id_fp_rs1/rs2/rs3/fp_rd,
//           id_long_int, id_long_fp, id_issue  - ID stage instruction
//           ex_kill                            - flush of the op in EX
//           cmpl_valid, cmpl_is_fp, cmpl_rd    - long-latency writeback
//           stall, busy_int, busy_fp, outstanding - scoreboard status
// Modports: master = pipeline/environment side, slave = scoreboard side.
// ---------------------------------------------------------------------------
interface hazard_scoreboard_if #(
  parameter int CW = 3
);
  logic          id_valid;
  logic [4:0]    id_rs1;
  logic [4:0]    id_rs2;
  logic [4:0]    id_rd;
  logic [4:0]    id_fp_rs1;
  logic [4:0]    id_fp_rs2;
  logic [4:0]    id_fp_rs3;
  logic [4:0]    id_fp_rd;
  logic          id_long_int;
  logic          id_long_fp;
  logic          id_issue;
  logic          ex_kill;
  logic          cmpl_valid;
  logic          cmpl_is_fp;
  logic [4:0]    cmpl_rd;
  logic          stall;
  logic [31:0]   busy_int;
  logic [31:0]   busy_fp;
  logic [CW-1:0] outstanding;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd,
    output id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_rd,
    output id_long_int, id_long_fp, id_issue, ex_kill,
    output cmpl_valid, cmpl_is_fp, cmpl_rd,
    input  stall, busy_int, busy_fp, outstanding
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd,
    input  id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_rd,
    input  id_long_int, id_long_fp, id_issue, ex_kill,
    input  cmpl_valid, cmpl_is_fp, cmpl_rd,
    output stall, busy_int, busy_fp, outstanding
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard
// Purpose : Tracks integer and FP registers that have a long-latency write in
//           flight and stalls ID when an operand or destination is still
//           pending, or when the in-flight limit is reached.
// Ports   : clk   - single clock, rising edge
//           reset - synchronous, active-high
//           sb    - hazard_scoreboard_if.slave (ID query, ex_kill,
//                   completion port, stall/busy_int/busy_fp/outstanding)
// Params  : MAX_OUTSTANDING - max long writes in flight (1..31)
//           CW              - width of the outstanding count
// Config  : SCOREBOARD_FP_EN - when defined, FP registers are tracked; when
//           undefined, busy_fp is 0 and all FP inputs are ignored.
// ---------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CW              = 3
) (
  input logic                clk,
  input logic                reset,
  hazard_scoreboard_if.slave sb
);

`ifdef SCOREBOARD_FP_EN
  localparam bit FpEn = 1'b1;
`else
  localparam bit FpEn = 1'b0;
`endif

  localparam logic [CW-1:0] MaxCnt = CW'(MAX_OUTSTANDING);

  logic [31:0]   busyInt_q, busyInt_d;
  logic [31:0]   busyFp_q, busyFp_d;
  logic          lastValid_q, lastValid_d;
  logic          lastIsFp_q, lastIsFp_d;
  logic [4:0]    lastRd_q, lastRd_d;
  logic [CW-1:0] count;

  logic cmplInt, cmplFp;
  logic longInt, longFp;
  logic freeing, srcHit, wawHit, full;
  logic stall, accept;

  // x0 is never pending; a same-cycle completion to rs bypasses the hazard.
  function automatic logic intHit(input logic [31:0] busy, input logic [4:0] rs,
                                  input logic byp, input logic [4:0] bypRd);
    return (rs != 5'd0) && busy[rs] && !(byp && (bypRd == rs));
  endfunction

  // f0 is an ordinary register, so no zero exclusion here.
  function automatic logic fpHit(input logic [31:0] busy, input logic [4:0] rs,
                                 input logic byp, input logic [4:0] bypRd);
    return busy[rs] && !(byp && (bypRd == rs));
  endfunction

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + CW'(busyInt_q[i]) + CW'(busyFp_q[i]);
    end
  end

  // Hazard detection. A completion only frees a slot when it hits a pending
  // register, so a stray completion cannot let the count exceed the limit.
  always_comb begin
    cmplInt = sb.cmpl_valid && !sb.cmpl_is_fp;
    cmplFp  = FpEn && sb.cmpl_valid && sb.cmpl_is_fp;
    longInt = sb.id_long_int;
    longFp  = FpEn && sb.id_long_fp;
    freeing = (cmplInt && busyInt_q[sb.cmpl_rd]) || (cmplFp && busyFp_q[sb.cmpl_rd]);

    srcHit = intHit(busyInt_q, sb.id_rs1, cmplInt, sb.cmpl_rd)
          || intHit(busyInt_q, sb.id_rs2, cmplInt, sb.cmpl_rd)
          || fpHit(busyFp_q, sb.id_fp_rs1, cmplFp, sb.cmpl_rd)
          || fpHit(busyFp_q, sb.id_fp_rs2, cmplFp, sb.cmpl_rd)
          || fpHit(busyFp_q, sb.id_fp_rs3, cmplFp, sb.cmpl_rd);

    wawHit = (longInt && intHit(busyInt_q, sb.id_rd, cmplInt, sb.cmpl_rd))
          || (longFp && fpHit(busyFp_q, sb.id_fp_rd, cmplFp, sb.cmpl_rd));

    full   = (longInt || longFp) && (count == MaxCnt) && !freeing;
    stall  = !reset && sb.id_valid && (srcHit || wawHit || full);
    accept = !reset && sb.id_issue && sb.id_valid && !stall;
  end

  // Next state: kill and completion clear first, then a new issue sets, so a
  // completion and an issue to the same register leave the bit set.
  always_comb begin
    busyInt_d = busyInt_q;
    busyFp_d  = busyFp_q;

    if (sb.ex_kill && lastValid_q) begin
      if (lastIsFp_q) busyFp_d[lastRd_q] = 1'b0;
      else            busyInt_d[lastRd_q] = 1'b0;
    end
    if (cmplInt) busyInt_d[sb.cmpl_rd] = 1'b0;
    if (cmplFp)  busyFp_d[sb.cmpl_rd]  = 1'b0;
    if (accept && longInt) busyInt_d[sb.id_rd]  = 1'b1;
    if (accept && longFp)  busyFp_d[sb.id_fp_rd] = 1'b1;

    busyInt_d[0] = 1'b0;
    if (!FpEn) busyFp_d = '0;

    lastValid_d = accept && (longInt || longFp);
    lastIsFp_d  = accept && longFp;
    lastRd_d    = longFp ? sb.id_fp_rd : sb.id_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busyInt_q   <= '0;
      busyFp_q    <= '0;
      lastValid_q <= 1'b0;
      lastIsFp_q  <= 1'b0;
      lastRd_q    <= '0;
    end else begin
      busyInt_q   <= busyInt_d;
      busyFp_q    <= busyFp_d;
      lastValid_q <= lastValid_d;
      lastIsFp_q  <= lastIsFp_d;
      lastRd_q    <= lastRd_d;
    end
  end

  assign sb.stall       = stall;
  assign sb.busy_int    = busyInt_q;
  assign sb.busy_fp     = busyFp_q;
  assign sb.outstanding = count;

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of long-latency writes in flight (legal range 1..31).
REQ-002 SHALL have parameter CW, default 3, meaning the width of the outstanding count (CW >= clog2(MAX_OUTSTANDING+1)).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port id_valid  input  1  a valid instruction is in ID.
REQ-006 SHALL have ports id_rs1, id_rs2, id_rd  input  5 each  integer sources and destination of the ID instruction.
REQ-007 SHALL have ports id_fp_rs1, id_fp_rs2, id_fp_rs3, id_fp_rd  input  5 each  FP sources and destination of the ID instruction.
REQ-008 SHALL have port id_long_int  input  1  the ID instruction writes id_rd via a long-latency path (load, MUL/DIV, atomic, FP-to-INT).
REQ-009 SHALL have port id_long_fp  input  1  the ID instruction writes id_fp_rd via a long-latency path (FP load, FDIV, FSQRT).
REQ-010 SHALL have port id_issue  input  1  the ID instruction advances into EX this cycle.
REQ-011 SHALL have port ex_kill  input  1  the instruction that entered EX in the previous cycle is flushed.
REQ-012 SHALL have ports cmpl_valid  input  1, cmpl_is_fp  input  1, and cmpl_rd  input  5  together forming the long-latency completion (writeback) port.
REQ-013 SHALL have port stall  output  1  ID must hold because forwarding cannot supply a correct operand.
REQ-014 SHALL have ports busy_int and busy_fp  output  32 each  per-register pending bits; busy_int[0] is always 0.
REQ-015 SHALL have port outstanding  output  CW  the number of set busy bits.

Function
REQ-016 An integer source SHALL hit when rs != 0 and busy_int[rs] is set, unless cmpl_valid && !cmpl_is_fp && cmpl_rd == rs in the same cycle (completion bypass).
REQ-017 An FP source SHALL hit when busy_fp[rs] is set (f0 included), unless an FP completion to the same register occurs in the same cycle.
REQ-018 A WAW hit SHALL occur when the ID instruction is long and its destination is busy and not completing this cycle; id_rd == 0 SHALL never cause a WAW hit.
REQ-019 stall SHALL be id_valid && (any source hit || WAW hit || ((id_long_int || id_long_fp) && outstanding == MAX_OUTSTANDING && no completion this cycle)); stall is combinational.
REQ-020 An issue SHALL be accepted when id_issue && id_valid && !stall; an issue while stall is asserted SHALL be ignored.
REQ-021 An accepted long issue SHALL set the destination busy bit on the next edge; a long integer issue to x0 SHALL set no bit.
REQ-022 A completion SHALL clear the target bit on the next edge; a completion to a non-busy register SHALL be ignored.
REQ-023 A completion and an accepted issue to the same register in the same cycle SHALL leave the bit set, with outstanding unchanged.
REQ-024 The block SHALL register {valid, is_fp, rd} of every accepted long issue for exactly one cycle (last-issue register).
REQ-025 ex_kill SHALL clear the last-issue bit on the next edge when the last-issue register is valid, and SHALL be ignored otherwise.
REQ-026 ex_kill SHALL have priority over a new issue to a different register in the same cycle; both actions SHALL take effect.
REQ-027 The environment SHALL guarantee a completion latency of >= 2 cycles after issue, so that kill and completion never target the same op.
REQ-028 outstanding SHALL equal popcount(busy_int) + popcount(busy_fp) at every edge.

Reset
REQ-029 While reset is high, stall SHALL be 0; busy_int, busy_fp, outstanding, and the last-issue register SHALL be 0 after the edge.
REQ-030 Reset SHALL have priority over issue, completion, and kill in the same cycle; in-flight ops SHALL be forgotten.

Configuration
REQ-031 With macro SCOREBOARD_FP_EN defined, FP tracking SHALL operate as specified above.
REQ-032 Without SCOREBOARD_FP_EN, busy_fp SHALL be constant 0; FP sources, id_long_fp, and FP completions SHALL be ignored; FP ops SHALL not count toward outstanding.

Verification
REQ-033 Issue a long write to x5, next cycle ID reads x5 -> stall=1 until cmpl_rd=5 arrives; in the completion cycle stall=0 (bypass) and busy_int[5]=0 after the edge.
REQ-034 Issue a long write to x0, then read x0 -> busy_int stays 0, stall=0, outstanding=0.
REQ-035 Issue long writes to x1..x4 with MAX_OUTSTANDING=4 -> a fifth long issue stalls; a completion of x2 in the same cycle -> no stall, and outstanding stays 4.
REQ-036 Issue to x7 then ex_kill next cycle -> busy_int[7]=0 and outstanding returns to 0; a subsequent cmpl_rd=7 is ignored.
REQ-037 Issue a long FDIV to f0 and read f0 -> stall=1 with SCOREBOARD_FP_EN defined; without the macro, stall=0 and busy_fp=0.
REQ-038 Apply reset with three ops in flight and id_issue high -> all outputs are 0 after the edge.
